// File: rtl/mux_param_registrado_pkg.sv
// Shared datapath constants and types for the registered pipeline-stage mux.
package mux_param_registrado_pkg;

   localparam int MUX_WIDTH = 32;
   localparam int CNT_STALL_W = 8;
   localparam logic [CNT_STALL_W-1:0] CNT_STALL_MAX = 8'd255;
   localparam logic [31:0] MUX_RESET_VAL = 32'h0;

   // Status bits that travel with the registered word through the stage
   typedef struct packed {
      logic valido;
      logic selInvalido;
   } flags_t;

endpackage

// File: rtl/mux_param_registrado_if.sv
// Bus bundle for the registered mux stage: channel data, select and
// pipeline controls going in, registered word and status coming out.
interface mux_param_registrado_if
   import mux_param_registrado_pkg::*;
#(
   parameter int WIDTH  = MUX_WIDTH,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
);

   logic [NUM_IN*WIDTH-1:0] entradas;
   logic [SEL_W-1:0]        sel;
   logic                    valido_in;
   logic                    habilitar;
   logic                    vaciar;
   logic [WIDTH-1:0]        salida;
   logic                    valido_out;
   logic                    sel_invalido;
   logic [CNT_STALL_W-1:0]  cnt_stall;

   modport master (
      output entradas, sel, valido_in, habilitar, vaciar,
      input  salida, valido_out, sel_invalido, cnt_stall
   );

   modport slave (
      input  entradas, sel, valido_in, habilitar, vaciar,
      output salida, valido_out, sel_invalido, cnt_stall
   );

endinterface

// File: rtl/mux_param_registrado_registro_etapa.sv
// Generic pipeline-stage register: reset beats flush, flush beats enable,
// and with neither the stored value is held (stall).
module registro_etapa #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vaciar,
   input  logic             habilitar,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Reset and flush both inject the reset value; otherwise advance or hold
   always_ff @(posedge clk) begin
      if (reset || vaciar) begin
         q <= RESET_VAL;
      end else if (habilitar) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mux_param_registrado.sv
// Registered N-input datapath mux: selects one channel, latches it behind a
// stall-able/flushable stage register and tracks illegal selects and how
// long a valid word has been stalled.
module mux_param_registrado
   import mux_param_registrado_pkg::*;
#(
   parameter int               WIDTH     = MUX_WIDTH,
   parameter int               NUM_IN    = 4,
   parameter int               SEL_W     = $clog2(NUM_IN),
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(MUX_RESET_VAL)
) (
   input logic                        clk,
   input logic                        reset,
   mux_param_registrado_if.slave      bus
);

   logic [SEL_W-1:0]       selIn;
   logic [WIDTH-1:0]       muxWord;
   logic                   selLegal;
   flags_t                 flagsNext;
   flags_t                 flagsQ;
   logic [WIDTH-1:0]       salidaQ;
   logic [CNT_STALL_W-1:0] cntStall;

   assign selIn = bus.sel;

   // Select decode: out-of-range selects fall through to the reset value,
   // which only matters when NUM_IN is not a power of two
   always_comb begin
      muxWord  = RESET_VAL;
      selLegal = 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (int'(selIn) == k) begin
            muxWord  = bus.entradas[k*WIDTH +: WIDTH];
            selLegal = 1'b1;
         end
      end
   end

   // Status to capture alongside the word; an illegal select is only
   // flagged for a word that is actually valid
   always_comb begin
      flagsNext.valido      = bus.valido_in;
      flagsNext.selInvalido = bus.valido_in & ~selLegal;
   end

   registro_etapa #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) uDatos (
      .clk       (clk),
      .reset     (reset),
      .vaciar    (bus.vaciar),
      .habilitar (bus.habilitar),
      .d         (muxWord),
      .q         (salidaQ)
   );

   registro_etapa #(
      .WIDTH     ($bits(flags_t)),
      .RESET_VAL ('0)
   ) uFlags (
      .clk       (clk),
      .reset     (reset),
      .vaciar    (bus.vaciar),
      .habilitar (bus.habilitar),
      .d         (flagsNext),
      .q         (flagsQ)
   );

   // Counts consecutive stalled edges while a valid word is held; saturates
   // rather than wrapping and clears on any advance, flush or reset
   always_ff @(posedge clk) begin
      if (reset || bus.vaciar || bus.habilitar) begin
         cntStall <= '0;
      end else if (flagsQ.valido && (cntStall != CNT_STALL_MAX)) begin
         cntStall <= cntStall + CNT_STALL_W'(1);
      end
   end

   assign bus.salida       = salidaQ;
   assign bus.valido_out   = flagsQ.valido;
   assign bus.sel_invalido = flagsQ.selInvalido;
   assign bus.cnt_stall    = cntStall;

endmodule
